// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/gnt/rvalid handshake, holds it for the decoder and computes the next PC.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | just out of reset; no request outstanding
// REQ    | imemReq high at pc, waiting for grant
// WAIT   | granted, waiting for the read response
// HOLD   | instr valid and stable, waiting for execDone to advance pc
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    input  logic [1:0]  pcSrcCtrl,
    input  logic        bneCtrl,
    input  logic [25:0] jAddr,
    input  logic [31:0] imm,
    input  logic [31:0] rsData,
    input  logic        aluZero,
    input  logic        execDone,
    output logic        addrErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] PC_INC4   = 2'd0;
    localparam logic [1:0] PC_J      = 2'd1;
    localparam logic [1:0] PC_JR     = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    state_t      state;
    state_t      state_nxt;
    logic        capture;
    logic        advance;
    logic [31:0] next_pc;
    logic        branch_taken;
    logic        jr_misaligned;

    assign pcPlus4  = pc + 32'd4;
    assign imemAddr = pc;

    always_comb begin
        branch_taken  = bneCtrl ? ~aluZero : aluZero;
        jr_misaligned = (pcSrcCtrl == PC_JR) && (rsData[1:0] != 2'b00);
        next_pc       = pcPlus4;
        case (pcSrcCtrl)
            PC_INC4:   next_pc = pcPlus4;
            PC_J:      next_pc = {pcPlus4[31:28], jAddr, 2'b00};
            PC_JR:     next_pc = {rsData[31:2], 2'b00};
            PC_BRANCH: next_pc = branch_taken ? (pcPlus4 + {imm[29:0], 2'b00}) : pcPlus4;
            default:   next_pc = pcPlus4;
        endcase
    end

    // Responses and execDone outside their own state are simply dropped.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        imemReq   = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                imemReq = 1'b1;
                if (imemGnt) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imemRvalid) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (execDone) begin
                    advance   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= 32'd0;
            instrValid <= 1'b0;
            addrErr    <= 1'b0;
        end else begin
            if (capture) begin
                instr      <= imemRdata;
                instrValid <= 1'b1;
            end
            if (advance) begin
                pc         <= next_pc;
                instrValid <= 1'b0;
                if (jr_misaligned) addrErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against an architectural PC model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [1:0]  pcSrcCtrl;
    logic        bneCtrl;
    logic [25:0] jAddr;
    logic [31:0] imm;
    logic [31:0] rsData;
    logic        aluZero;
    logic        execDone;
    logic        addrErr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic        m_err;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
        .imemRvalid(imemRvalid), .imemRdata(imemRdata),
        .instr(instr), .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4),
        .pcSrcCtrl(pcSrcCtrl), .bneCtrl(bneCtrl), .jAddr(jAddr), .imm(imm),
        .rsData(rsData), .aluZero(aluZero), .execDone(execDone), .addrErr(addrErr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int cnt = 0;
        while (imemReq !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check_eq(tag, imemReq, 1'b1);
    endtask

    // Architectural next-PC rule written with plain arithmetic.
    task automatic model_step(input logic [1:0] src, input logic bne, input logic [25:0] ja,
                              input logic [31:0] im, input logic [31:0] rs, input logic z);
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        case (src)
            2'd0: m_pc = p4;
            2'd1: m_pc = (p4 & 32'hF000_0000) | (32'(ja) * 32'd4);
            2'd2: begin
                m_pc = rs & 32'hFFFF_FFFC;
                if ((rs % 4) != 0) m_err = 1'b1;
            end
            default: m_pc = ((bne && !z) || (!bne && z)) ? p4 + im * 32'd4 : p4;
        endcase
    endtask

    task automatic fetch(input logic [31:0] word, input logic [1:0] src, input logic bne,
                         input logic [25:0] ja, input logic [31:0] im, input logic [31:0] rs,
                         input logic z, input int gstall, input int rvdel, input int hold);
        wait_req("req_seen");
        check_eq("req_addr", imemAddr, m_pc);
        check_eq("pc_in_req", pc, m_pc);
        check_eq("pc_plus4", pcPlus4, m_pc + 32'd4);
        check_eq("valid_in_req", instrValid, 1'b0);
        for (int i = 0; i < gstall; i++) begin
            imemRvalid = 1'($urandom_range(0, 1));
            imemRdata  = $urandom;
            tick();
            check_eq("req_stall_held", imemReq, 1'b1);
            check_eq("req_stall_addr", imemAddr, m_pc);
            check_eq("req_stall_valid", instrValid, 1'b0);
        end
        imemRvalid = 1'b0;
        imemGnt    = 1'b1;
        tick();
        imemGnt = 1'b0;
        check_eq("wait_req_low", imemReq, 1'b0);
        for (int i = 0; i < rvdel; i++) begin
            execDone  = 1'($urandom_range(0, 1));
            pcSrcCtrl = 2'($urandom_range(0, 3));
            rsData    = $urandom;
            tick();
            check_eq("wait_valid", instrValid, 1'b0);
            check_eq("wait_pc", pc, m_pc);
            check_eq("wait_req", imemReq, 1'b0);
        end
        execDone   = 1'b0;
        imemRvalid = 1'b1;
        imemRdata  = word;
        tick();
        imemRvalid = 1'b0;
        check_eq("hold_valid", instrValid, 1'b1);
        check_eq("hold_instr", instr, word);
        for (int i = 0; i < hold; i++) begin
            imemRvalid = 1'($urandom_range(0, 1));
            imemRdata  = ~word;
            pcSrcCtrl  = 2'($urandom_range(0, 3));
            tick();
            check_eq("hold_instr_stable", instr, word);
            check_eq("hold_valid_stable", instrValid, 1'b1);
            check_eq("hold_pc_stable", pc, m_pc);
            check_eq("hold_req_low", imemReq, 1'b0);
        end
        imemRvalid = 1'b0;
        pcSrcCtrl  = src;
        bneCtrl    = bne;
        jAddr      = ja;
        imm        = im;
        rsData     = rs;
        aluZero    = z;
        execDone   = 1'b1;
        tick();
        execDone  = 1'b0;
        pcSrcCtrl = 2'($urandom_range(0, 3));
        rsData    = $urandom;
        imm       = $urandom;
        model_step(src, bne, ja, im, rs, z);
        check_eq("adv_pc", pc, m_pc);
        check_eq("adv_valid", instrValid, 1'b0);
        check_eq("adv_req", imemReq, 1'b1);
        check_eq("adv_addr", imemAddr, m_pc);
        check_eq("adv_addr_err", addrErr, m_err);
    endtask

    task automatic jump_to(input logic [31:0] target);
        fetch($urandom, 2'd2, 1'b0, 26'd0, 32'd0, target, 1'b0, 0, 0, 0);
    endtask

    task automatic reset_in_wait();
        wait_req("rst_req_seen");
        imemGnt = 1'b1;
        tick();
        imemGnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_pc  = RST_PC;
        m_err = 1'b0;
        check_eq("rst_async_pc", pc, RST_PC);
        check_eq("rst_async_req", imemReq, 1'b0);
        check_eq("rst_async_valid", instrValid, 1'b0);
        check_eq("rst_async_instr", instr, 32'd0);
        check_eq("rst_async_err", addrErr, 1'b0);
        tick();
        rst_n      = 1'b1;
        imemRvalid = 1'b1;
        imemRdata  = 32'hDEAD_BEEF;
        check_eq("rst_rel_req_low", imemReq, 1'b0);
        tick();
        imemRvalid = 1'b0;
        check_eq("rst_refetch_req", imemReq, 1'b1);
        check_eq("rst_refetch_addr", imemAddr, RST_PC);
        check_eq("rst_stale_valid", instrValid, 1'b0);
        check_eq("rst_stale_instr", instr, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        imemGnt    = 1'b0;
        imemRvalid = 1'b0;
        imemRdata  = 32'd0;
        pcSrcCtrl  = 2'd0;
        bneCtrl    = 1'b0;
        jAddr      = 26'd0;
        imm        = 32'd0;
        rsData     = 32'd0;
        aluZero    = 1'b0;
        execDone   = 1'b0;
        m_pc       = RST_PC;
        m_err      = 1'b0;
        repeat (2) tick();
        check_eq("reset_pc", pc, RST_PC);
        check_eq("reset_req", imemReq, 1'b0);
        check_eq("reset_valid", instrValid, 1'b0);
        check_eq("reset_instr", instr, 32'd0);
        check_eq("reset_err", addrErr, 1'b0);
        rst_n = 1'b1;
        check_eq("idle_req_low", imemReq, 1'b0);
        tick();
        check_eq("first_req", imemReq, 1'b1);
        check_eq("first_addr", imemAddr, 32'h100);

        fetch(32'h2010_0005, 2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 1'b0, 2, 1, 2);
        check_eq("seq_next_addr", imemAddr, 32'h104);

        jump_to(32'h200);
        fetch($urandom, 2'd3, 1'b0, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 0, 0, 0);
        check_eq("beq_taken", pc, 32'h1FC);
        jump_to(32'h200);
        fetch($urandom, 2'd3, 1'b1, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 0, 0, 0);
        check_eq("bne_not_taken", pc, 32'h204);

        jump_to(32'hF000_0010);
        fetch($urandom, 2'd1, 1'b0, 26'h40, 32'd0, 32'd0, 1'b0, 1, 0, 1);
        check_eq("j_target", pc, 32'hF000_0100);

        jump_to(32'h0000_0302);
        check_eq("jr_misaligned_pc", pc, 32'h300);
        check_eq("jr_addr_err", addrErr, 1'b1);

        jump_to(32'hFFFF_FFFC);
        fetch($urandom, 2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 1'b0, 0, 0, 0);
        check_eq("wrap_addr", imemAddr, 32'h0);
        check_eq("err_sticky", addrErr, 1'b1);

        reset_in_wait();

        for (int n = 0; n < 60; n++) begin
            logic [31:0] rs;
            rs = $urandom;
            if ($urandom_range(0, 7) != 0) rs = rs & 32'hFFFF_FFFC;
            fetch($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  26'($urandom), $urandom, rs, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            if (n % 20 == 19) reset_in_wait();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
